// File: rtl/alu_wide_seq.sv
// ---------------------------------------------------------------------------
// alu_wide_seq_defs_pkg
//   Opcode and function encodings shared by the 8-bit ALU and the 16-bit
//   sequencer that drives it. Function codes are interpreted per opcode class,
//   so the logic and shift functions deliberately reuse the same code points.
// ---------------------------------------------------------------------------
package alu_wide_seq_defs_pkg;

    localparam logic [1:0] opADD   = 2'b00;
    localparam logic [1:0] opLOGIC = 2'b01;
    localparam logic [1:0] opSHIFT = 2'b10;
    localparam logic [1:0] opPASS  = 2'b11;

    localparam logic [1:0] fnAND = 2'b00;
    localparam logic [1:0] fnOR  = 2'b01;
    localparam logic [1:0] fnXOR = 2'b10;
    localparam logic [1:0] fnNOT = 2'b11;

    // _X variants shift in a zero, _O variants shift in OVERFLOW_IN.
    localparam logic [1:0] fnSHIFTL_X = 2'b00;
    localparam logic [1:0] fnSHIFTL_O = 2'b01;
    localparam logic [1:0] fnSHIFTR_X = 2'b10;
    localparam logic [1:0] fnSHIFTR_O = 2'b11;

endpackage

// ---------------------------------------------------------------------------
// alu8
//   8-bit combinational ALU: add with carry, bitwise logic, one-bit shifts
//   and a pass-through.
// Ports:
//   op           in  2  operation class (opADD/opLOGIC/opSHIFT/opPASS)
//   func         in  2  function within the class
//   input_a      in  8  first operand / shift source
//   input_b      in  8  second operand
//   overflow_in  in  1  carry in for add, fill bit for _O shifts
//   flag_in      in  1  selects input_b on pass-through
//   result_out   out 8  result byte
//   overflow_out out 1  carry out of add, or the bit shifted out
//   flag_out     out 1  zero flag of result_out
// ---------------------------------------------------------------------------
module alu8
    import alu_wide_seq_defs_pkg::*;
(
    input  logic [1:0] op,
    input  logic [1:0] func,
    input  logic [7:0] input_a,
    input  logic [7:0] input_b,
    input  logic       overflow_in,
    input  logic       flag_in,
    output logic [7:0] result_out,
    output logic       overflow_out,
    output logic       flag_out
);

    logic [8:0] sum;

    always_comb begin
        sum          = '0;
        result_out   = '0;
        overflow_out = 1'b0;
        case (op)
            opADD: begin
                sum          = {1'b0, input_a} + {1'b0, input_b} + {8'b0, overflow_in};
                result_out   = sum[7:0];
                overflow_out = sum[8];
            end
            opLOGIC: begin
                case (func)
                    fnAND:   result_out = input_a & input_b;
                    fnOR:    result_out = input_a | input_b;
                    fnXOR:   result_out = input_a ^ input_b;
                    default: result_out = ~input_a;
                endcase
            end
            opSHIFT: begin
                case (func)
                    fnSHIFTL_X: begin
                        result_out   = {input_a[6:0], 1'b0};
                        overflow_out = input_a[7];
                    end
                    fnSHIFTL_O: begin
                        result_out   = {input_a[6:0], overflow_in};
                        overflow_out = input_a[7];
                    end
                    fnSHIFTR_X: begin
                        result_out   = {1'b0, input_a[7:1]};
                        overflow_out = input_a[0];
                    end
                    default: begin
                        result_out   = {overflow_in, input_a[7:1]};
                        overflow_out = input_a[0];
                    end
                endcase
            end
            default: begin
                result_out = flag_in ? input_b : input_a;
            end
        endcase
        flag_out = (result_out == 8'h00);
    end

endmodule

// ---------------------------------------------------------------------------
// alu_wide_seq
//   Multi-cycle helper that performs 16-bit add, subtract and multi-bit
//   logical shifts by running the 8-bit ALU over the low and high bytes in
//   successive cycles, chaining the ALU carry through a register.
// Ports:
//   CLK    in  1      clock, rising edge
//   RESET  in  1      synchronous active-high reset
//   START  in  1      command strobe, only honoured while idle
//   CMD    in  2      00 ADD16, 01 SUB16, 10 SHL16, 11 SHR16
//   OPA    in  16     operand A / shift source
//   OPB    in  16     operand B (ignored for shifts)
//   SHAMT  in  SHW    shift count (ignored for add/sub)
//   BUSY   out 1      high whenever not idle
//   DONE   out 1      one-cycle completion pulse
//   RESULT out 16     result, valid from DONE until the next accepted START
//   CARRY  out 1      final carry / last bit shifted out, held with RESULT
// ---------------------------------------------------------------------------
module alu_wide_seq
    import alu_wide_seq_defs_pkg::*;
#(
    parameter int SHW = 4
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           START,
    input  logic [1:0]     CMD,
    input  logic [15:0]    OPA,
    input  logic [15:0]    OPB,
    input  logic [SHW-1:0] SHAMT,
    output logic           BUSY,
    output logic           DONE,
    output logic [15:0]    RESULT,
    output logic           CARRY
);

    localparam logic [1:0] CMD_ADD = 2'b00;
    localparam logic [1:0] CMD_SUB = 2'b01;
    localparam logic [1:0] CMD_SHL = 2'b10;
    localparam logic [1:0] CMD_SHR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LO   = 2'b01,
        HI   = 2'b10,
        FIN  = 2'b11
    } state_e;

    state_e         state_q;
    state_e         state_d;
    logic [1:0]     cmd_q;
    logic [15:0]    w_q;
    logic [15:0]    b_q;
    logic           carry_q;
    logic [SHW-1:0] count_q;
    logic [SHW-1:0] count_dec;
    logic [15:0]    result_q;
    logic           carry_out_q;

    logic [1:0]     alu_op;
    logic [1:0]     alu_func;
    logic [7:0]     alu_a;
    logic [7:0]     alu_b;
    logic           alu_ovf_in;
    logic [7:0]     alu_out;
    logic           alu_ovf_out;
    logic           alu_flag_unused;
    logic           write_hi_byte;
    logic           cmd_is_shift;

    assign cmd_is_shift = cmd_q[1];
    assign count_dec    = count_q - SHW'(1);

    alu8 u_alu (
        .op           (alu_op),
        .func         (alu_func),
        .input_a      (alu_a),
        .input_b      (alu_b),
        .overflow_in  (alu_ovf_in),
        .flag_in      (1'b0),
        .result_out   (alu_out),
        .overflow_out (alu_ovf_out),
        .flag_out     (alu_flag_unused)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A shift of zero skips the byte passes entirely; shifts
    // loop LO/HI once per bit, the count being decremented in HI.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    if (CMD[1] && (SHAMT == '0)) begin
                        state_d = FIN;
                    end else begin
                        state_d = LO;
                    end
                end
            end
            LO: state_d = HI;
            HI: begin
                if (!cmd_is_shift || (count_dec == '0)) begin
                    state_d = FIN;
                end else begin
                    state_d = LO;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ALU drive. Left shifts and arithmetic start from the low byte so the
    // carry propagates upward; right shifts start from the high byte so the
    // bit leaving the high byte is fed into the top of the low byte.
    always_comb begin
        alu_op        = opADD;
        alu_func      = fnSHIFTL_X;
        alu_a         = 8'h00;
        alu_b         = 8'h00;
        alu_ovf_in    = 1'b0;
        write_hi_byte = 1'b0;
        case (state_q)
            LO: begin
                case (cmd_q)
                    CMD_ADD, CMD_SUB: begin
                        alu_a      = w_q[7:0];
                        alu_b      = b_q[7:0];
                        alu_ovf_in = (cmd_q == CMD_SUB);
                    end
                    CMD_SHL: begin
                        alu_op   = opSHIFT;
                        alu_func = fnSHIFTL_X;
                        alu_a    = w_q[7:0];
                    end
                    default: begin
                        alu_op        = opSHIFT;
                        alu_func      = fnSHIFTR_X;
                        alu_a         = w_q[15:8];
                        write_hi_byte = 1'b1;
                    end
                endcase
            end
            HI: begin
                alu_ovf_in = carry_q;
                case (cmd_q)
                    CMD_ADD, CMD_SUB: begin
                        alu_a         = w_q[15:8];
                        alu_b         = b_q[15:8];
                        write_hi_byte = 1'b1;
                    end
                    CMD_SHL: begin
                        alu_op        = opSHIFT;
                        alu_func      = fnSHIFTL_O;
                        alu_a         = w_q[15:8];
                        write_hi_byte = 1'b1;
                    end
                    default: begin
                        alu_op   = opSHIFT;
                        alu_func = fnSHIFTR_O;
                        alu_a    = w_q[7:0];
                    end
                endcase
            end
            default: begin
                alu_op = opADD;
            end
        endcase
    end

    // Datapath registers. Subtraction is done as A + ~B + 1, so B is stored
    // inverted and the +1 enters as the low-byte carry in.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cmd_q       <= CMD_ADD;
            w_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            count_q     <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        cmd_q   <= CMD;
                        w_q     <= OPA;
                        b_q     <= (CMD == CMD_SUB) ? ~OPB : OPB;
                        count_q <= SHAMT;
                        carry_q <= 1'b0;
                    end
                end
                LO, HI: begin
                    if (write_hi_byte) begin
                        w_q[15:8] <= alu_out;
                    end else begin
                        w_q[7:0] <= alu_out;
                    end
                    carry_q <= alu_ovf_out;
                    if ((state_q == HI) && cmd_is_shift) begin
                        count_q <= count_dec;
                    end
                end
                default: begin
                    result_q    <= w_q;
                    carry_out_q <= carry_q;
                end
            endcase
        end
    end

    // During FIN the result register is only being loaded, so the outputs
    // bypass it with the work register to make RESULT valid alongside DONE.
    always_comb begin
        BUSY   = (state_q != IDLE);
        DONE   = (state_q == FIN);
        RESULT = (state_q == FIN) ? w_q : result_q;
        CARRY  = (state_q == FIN) ? carry_q : carry_out_q;
    end

endmodule
